// File: rtl/fifo_serializer_pkg.sv
// Shared types and sizing helpers for fifo_serializer.
package fifo_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int idx_w(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_serializer.sv
// Drains a wide Fifo1 via first/deq and pushes WIDTH/CHUNK narrow beats into enq.
// Define FIFO_SERIALIZER_MSB_FIRST_EN to emit the most-significant chunk first.
module fifo_serializer
    import fifo_serializer_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int CHUNK = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] in_first,
    input  logic             in_first__RDY,
    output logic             in_deq__ENA,
    input  logic             in_deq__RDY,
    output logic             out_enq__ENA,
    output logic [CHUNK-1:0] out_enq_v,
    input  logic             out_enq__RDY
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = idx_w(WIDTH, CHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("fifo_serializer: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t             r_st;
    state_t             w_st_nx;
    logic [WIDTH-1:0]   r_hold;
    logic [WIDTH-1:0]   w_hold_nx;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nx;
    logic               w_avail;
    logic [WIDTH-1:0]   w_hold_shift;

    assign w_avail = in_first__RDY & in_deq__RDY;

`ifdef FIFO_SERIALIZER_MSB_FIRST_EN
    assign out_enq_v    = r_hold[WIDTH-1:WIDTH-CHUNK];
    assign w_hold_shift = r_hold << CHUNK;
`else
    assign out_enq_v    = r_hold[CHUNK-1:0];
    assign w_hold_shift = r_hold >> CHUNK;
`endif

    always_comb begin
        w_st_nx      = r_st;
        w_hold_nx    = r_hold;
        w_idx_nx     = r_idx;
        in_deq__ENA  = 1'b0;
        out_enq__ENA = 1'b0;
        if (!RST) begin
            case (r_st)
                IDLE: begin
                    in_deq__ENA = w_avail;
                    if (w_avail) begin
                        w_hold_nx = in_first;
                        w_idx_nx  = '0;
                        w_st_nx   = BUSY;
                    end
                end
                BUSY: begin
                    out_enq__ENA = out_enq__RDY;
                    if (out_enq__RDY) begin
                        if (r_idx == LAST_IDX) begin
                            // Refill on the last beat so consecutive words have no bubble.
                            w_idx_nx = '0;
                            if (w_avail) begin
                                in_deq__ENA = 1'b1;
                                w_hold_nx   = in_first;
                            end else begin
                                w_st_nx = IDLE;
                            end
                        end else begin
                            w_hold_nx = w_hold_shift;
                            w_idx_nx  = r_idx + 1'b1;
                        end
                    end
                end
                default: w_st_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_st   <= IDLE;
            r_hold <= '0;
            r_idx  <= '0;
        end else begin
            r_st   <= w_st_nx;
            r_hold <= w_hold_nx;
            r_idx  <= w_idx_nx;
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// Self-checking bench for fifo_serializer: queue-based upstream/downstream models and a beat scoreboard.
module tb_fifo_serializer;

    localparam int WIDTH  = 15;
    localparam int CHUNK  = 5;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [WIDTH-1:0] in_first = '0;
    logic             in_first_rdy = 1'b0;
    logic             in_deq_ena;
    logic             in_deq_rdy = 1'b0;
    logic             out_enq_ena;
    logic [CHUNK-1:0] out_enq_v;
    logic             out_enq_rdy = 1'b0;

    fifo_serializer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_first     (in_first),
        .in_first__RDY(in_first_rdy),
        .in_deq__ENA  (in_deq_ena),
        .in_deq__RDY  (in_deq_rdy),
        .out_enq__ENA (out_enq_ena),
        .out_enq_v    (out_enq_v),
        .out_enq__RDY (out_enq_rdy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Upstream words and read pointer; downstream expected beats.
    logic [WIDTH-1:0] src[$];
    int               src_rd = 0;
    logic [CHUNK-1:0] exp_q[$];

    // Fire logs for directed timing checks.
    logic [CHUNK-1:0] beat_v[$];
    int               beat_c[$];
    int               deq_c[$];

    int p_first = 100;
    int p_deq   = 100;
    int p_out   = 100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [CHUNK-1:0] beat_of(input logic [WIDTH-1:0] w, input int k);
        int pos;
`ifdef FIFO_SERIALIZER_MSB_FIRST_EN
        pos = NCHUNK - 1 - k;
`else
        pos = k;
`endif
        return CHUNK'((w >> (CHUNK * pos)) & ((1 << CHUNK) - 1));
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Random handshake driver, updated just after each edge.
    always @(posedge CLK) begin
        #1;
        in_first_rdy = (src_rd < src.size()) && ($urandom_range(99) < p_first);
        in_first     = (src_rd < src.size()) ? src[src_rd] : '0;
        in_deq_rdy   = ($urandom_range(99) < p_deq);
        out_enq_rdy  = ($urandom_range(99) < p_out);
    end

    // Compare process: inputs are stable here and commit at the next edge.
    always @(negedge CLK) begin
        if (RST) begin
            chk("rst_deq_ena", in_deq_ena, 1'b0);
            chk("rst_enq_ena", out_enq_ena, 1'b0);
            exp_q.delete();
        end else begin
            chk("deq_legal", in_deq_ena & ~(in_first_rdy & in_deq_rdy), 1'b0);
            chk("enq_legal", out_enq_ena & ~out_enq_rdy, 1'b0);
            if (out_enq_ena && out_enq_rdy) begin
                if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
                else chk("beat", out_enq_v, exp_q.pop_front());
                beat_v.push_back(out_enq_v);
                beat_c.push_back(cyc);
            end
            if (in_deq_ena && in_first_rdy && in_deq_rdy) begin
                for (int k = 0; k < NCHUNK; k++) exp_q.push_back(beat_of(in_first, k));
                deq_c.push_back(cyc);
                src_rd++;
            end
        end
    end

    task automatic clear_logs();
        beat_v.delete();
        beat_c.delete();
        deq_c.delete();
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (beat_v.size() < n && t < budget) begin
            @(posedge CLK);
            t++;
        end
        if (beat_v.size() < n) chk({name, "_timeout"}, beat_v.size(), n);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int t;
        t = 0;
        while ((src_rd < src.size() || exp_q.size() != 0) && t < budget) begin
            @(posedge CLK);
            t++;
        end
        if (src_rd < src.size() || exp_q.size() != 0) chk({name, "_timeout"}, src_rd, src.size());
        repeat (2) @(posedge CLK);
    endtask

    logic [CHUNK-1:0] exp1[3];

    initial begin
`ifdef FIFO_SERIALIZER_MSB_FIRST_EN
        exp1[0] = 5'h1E; exp1[1] = 5'h12; exp1[2] = 5'h1C;
`else
        exp1[0] = 5'h1C; exp1[1] = 5'h12; exp1[2] = 5'h1E;
`endif
        // Reset with an upstream word already waiting.
        src.push_back(15'h7A5C);
        repeat (3) begin
            @(posedge CLK);
            @(negedge CLK);
            chk("rst_v", out_enq_v, 5'h00);
        end
        @(posedge CLK);
        clear_logs();
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rel_deq_ena", in_deq_ena, 1'b1);

        // Single word, downstream always ready.
        wait_beats(3, 50, "single");
        for (int i = 0; i < 3; i++) chk("single_val", beat_v[i], exp1[i]);
        chk("single_lat", beat_c[0], deq_c[0] + 1);
        chk("single_b2", beat_c[1], beat_c[0] + 1);
        chk("single_b3", beat_c[2], beat_c[1] + 1);
        wait_drain(50, "single");

        // Back-to-back words, no bubble between them.
        clear_logs();
        src.push_back(15'h7A5C);
        src.push_back(15'h0421);
        wait_beats(6, 60, "b2b");
        for (int i = 0; i < 3; i++) chk("b2b_w0", beat_v[i], exp1[i]);
        for (int i = 3; i < 6; i++) chk("b2b_w1", beat_v[i], 5'h01);
        for (int i = 1; i < 6; i++) chk("b2b_consec", beat_c[i], beat_c[0] + i);
        chk("b2b_deq_ndeq", deq_c.size(), 2);
        chk("b2b_deq_at_b3", deq_c[1], beat_c[2]);
        wait_drain(50, "b2b");

        // Backpressure after beat 1.
        clear_logs();
        src.push_back(15'h7A5C);
        wait_beats(1, 50, "bp");
        p_out = 0;
        repeat (4) begin
            @(negedge CLK);
            chk("bp_hold_v", out_enq_v, exp1[1]);
            chk("bp_enq_ena", out_enq_ena, 1'b0);
            chk("bp_deq_ena", in_deq_ena, 1'b0);
        end
        p_out = 100;
        wait_beats(3, 50, "bp");
        chk("bp_b2", beat_v[1], exp1[1]);
        chk("bp_b3", beat_v[2], exp1[2]);
        chk("bp_ndeq", deq_c.size(), 1);
        wait_drain(50, "bp");

        // Reset after beat 2: remaining beat is dropped, next word starts clean.
        clear_logs();
        src.push_back(15'h7A5C);
        src.push_back(15'h0421);
        wait_beats(2, 50, "mrst");
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        wait_beats(5, 50, "mrst");
        wait_drain(50, "mrst");
        chk("mrst_b1", beat_v[0], exp1[0]);
        chk("mrst_b2", beat_v[1], exp1[1]);
        chk("mrst_next", beat_v[2], 5'h01);
        chk("mrst_nbeats", beat_v.size(), 5);
        chk("mrst_ndeq", deq_c.size(), 2);
        chk("mrst_src", src_rd, src.size());

        // Random stalls on both sides.
        clear_logs();
        p_first = 70;
        p_deq   = 80;
        p_out   = 60;
        for (int i = 0; i < 1000; i++) src.push_back(WIDTH'($urandom));
        wait_drain(40000, "rand");
        chk("rand_ndeq", deq_c.size(), 1000);
        chk("rand_nbeats", beat_v.size(), 1000 * NCHUNK);
        chk("rand_src", src_rd, src.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
